// File: rtl/reg_load_sequencer.sv
// Push-button write sequencer: synchronises and debounces a raw button, then issues
// one write strobe per accepted press with a wrapping register pointer and a running load count.
module reg_load_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int NUM_REGS        = 4,
  parameter int DATA_W          = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        btn_raw,
  input  logic                        en,
  input  logic [DATA_W-1:0]           din,
  output logic                        wr_strobe,
  output logic [$clog2(NUM_REGS)-1:0] wr_addr,
  output logic [DATA_W-1:0]           wr_data,
  output logic [7:0]                  load_count,
  output logic                        busy
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] PTR_MAX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] ptr;
  logic              s1;
  logic              s2;

  // NUM_REGS need not be a power of two, so wrap explicitly.
  function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
    return (p == PTR_MAX) ? '0 : p + ADDR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      state      <= IDLE;
      cnt        <= '0;
      ptr        <= '0;
      wr_strobe  <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      load_count <= '0;
      busy       <= 1'b0;
    end else begin
      s1        <= btn_raw;
      s2        <= s1;
      wr_strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (s2) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        PRESS_WAIT: begin
          if (!s2) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_MAX) begin
            state <= HELD;
            cnt   <= '0;
            // A disabled press is still consumed; only the write side effects are skipped.
            if (en) begin
              wr_strobe  <= 1'b1;
              wr_addr    <= ptr;
              wr_data    <= din;
              ptr        <= next_ptr(ptr);
              load_count <= load_count + 8'd1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HELD: begin
          if (!s2) begin
            state <= REL_WAIT;
            cnt   <= '0;
          end
        end
        REL_WAIT: begin
          if (s2) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_load_sequencer.sv
// Bench for reg_load_sequencer: directed scenarios plus randomized button traffic
// checked against a run-length model of the debounced press/release behaviour.
module tb_reg_load_sequencer;

  localparam int D  = 4;
  localparam int NR = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn_raw = 1'b0;
  logic       en = 1'b0;
  logic [7:0] din = 8'h00;
  logic       wr_strobe;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] load_count;
  logic       busy;

  reg_load_sequencer #(.DEBOUNCE_CYCLES(D), .NUM_REGS(NR), .DATA_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .btn_raw(btn_raw), .en(en), .din(din),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .load_count(load_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: pressed/released phase plus the length of the current run of
  // synchronised samples disagreeing with that phase; D+1 such samples flip the phase.
  bit         m_h1, m_h2;
  bit         m_pressed;
  int         m_run;
  int         m_ptr;
  logic [1:0] m_addr;
  logic [7:0] m_data;
  logic [7:0] m_count;
  bit         m_strobe;
  bit         m_busy;

  task automatic model_clear();
    m_h1 = 0; m_h2 = 0; m_pressed = 0; m_run = 0; m_ptr = 0;
    m_addr = '0; m_data = '0; m_count = '0; m_strobe = 0; m_busy = 0;
  endtask

  task automatic step(input bit b, input bit e, input logic [7:0] d);
    bit seen;
    btn_raw = b; en = e; din = d;
    @(posedge clk);
    seen = m_h2;
    m_h2 = m_h1;
    m_h1 = b;
    m_strobe = 0;
    if (seen != m_pressed) begin
      m_run++;
      if (m_run == D + 1) begin
        m_pressed = !m_pressed;
        m_run = 0;
        if (m_pressed && e) begin
          m_strobe = 1;
          m_addr   = 2'(m_ptr);
          m_data   = d;
          m_ptr    = (m_ptr + 1) % NR;
          m_count  = m_count + 8'd1;
        end
      end
    end else begin
      m_run = 0;
    end
    m_busy = m_pressed || (m_run > 0);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    model_clear();
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    btn_raw = 1'b0;
    do_reset();
    total += 5;
    if (wr_strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe got=%0h want=0", wr_strobe); end
    if (wr_addr !== 2'd0) begin bad++; $display("FAIL reset_addr got=%0h want=0", wr_addr); end
    if (wr_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%0h want=0", wr_data); end
    if (load_count !== 8'h00) begin bad++; $display("FAIL reset_count got=%0h want=0", load_count); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h want=0", busy); end
  endtask

  task automatic test_clean_press();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 8'hA5);
      total++;
      if (wr_strobe !== (i == 6)) begin
        bad++; $display("FAIL clean_strobe cyc=%0d got=%0h want=%0h", i, wr_strobe, (i == 6));
      end
      if (i == 6) begin
        total += 3;
        if (wr_addr !== 2'd0) begin bad++; $display("FAIL clean_addr got=%0h want=0", wr_addr); end
        if (wr_data !== 8'hA5) begin bad++; $display("FAIL clean_data got=%0h want=a5", wr_data); end
        if (load_count !== 8'd1) begin bad++; $display("FAIL clean_count got=%0d want=1", load_count); end
      end
    end
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'hA5);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL clean_idle busy got=%0h want=0", busy); end
  endtask

  task automatic test_glitch();
    int strobes = 0;
    for (int i = 0; i < 11; i++) begin
      step(i < 3, 1'b1, 8'h5A);
      if (wr_strobe === 1'b1) strobes++;
      total++;
      if (busy !== m_busy) begin bad++; $display("FAIL glitch_busy cyc=%0d got=%0h want=%0h", i, busy, m_busy); end
    end
    total += 3;
    if (strobes != 0) begin bad++; $display("FAIL glitch_strobes got=%0d want=0", strobes); end
    if (busy !== 1'b0) begin bad++; $display("FAIL glitch_idle busy got=%0h want=0", busy); end
    if (load_count !== 8'd1) begin bad++; $display("FAIL glitch_count got=%0d want=1", load_count); end
  endtask

  task automatic test_bounce();
    int strobes = 0;
    bit rel_pat [14] = '{0,1,0,1,0,0,0,0,0,0,0,0,0,0};
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 8'h11);
      if (wr_strobe === 1'b1) strobes++;
    end
    for (int i = 0; i < 14; i++) begin
      step(rel_pat[i], 1'b1, 8'h11);
      if (wr_strobe === 1'b1) strobes++;
      total++;
      if (busy !== m_busy) begin bad++; $display("FAIL bounce_busy cyc=%0d got=%0h want=%0h", i, busy, m_busy); end
      if (i == 9 || i == 10) begin
        total++;
        if (busy !== (i == 9)) begin bad++; $display("FAIL bounce_release cyc=%0d got=%0h want=%0h", i, busy, (i == 9)); end
      end
    end
    total += 3;
    if (strobes != 1) begin bad++; $display("FAIL bounce_strobes got=%0d want=1", strobes); end
    if (load_count !== 8'd2) begin bad++; $display("FAIL bounce_count got=%0d want=2", load_count); end
    if (wr_data !== 8'h11) begin bad++; $display("FAIL bounce_data got=%0h want=11", wr_data); end
  endtask

  task automatic test_wrap();
    int strobes = 0;
    do_reset();
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < 16; i++) begin
        step(i < 8, 1'b1, 8'(p + 1));
        if (wr_strobe === 1'b1) begin
          strobes++;
          total += 2;
          if (wr_addr !== 2'(p % 4)) begin bad++; $display("FAIL wrap_addr press=%0d got=%0d want=%0d", p, wr_addr, p % 4); end
          if (wr_data !== 8'(p + 1)) begin bad++; $display("FAIL wrap_data press=%0d got=%0h want=%0h", p, wr_data, p + 1); end
        end
      end
    end
    total += 2;
    if (strobes != 5) begin bad++; $display("FAIL wrap_strobes got=%0d want=5", strobes); end
    if (load_count !== 8'd5) begin bad++; $display("FAIL wrap_count got=%0d want=5", load_count); end
  endtask

  task automatic test_disabled();
    int strobes = 0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(i < 8, 1'b0, 8'hEE);
      if (wr_strobe === 1'b1) strobes++;
    end
    total += 2;
    if (strobes != 0) begin bad++; $display("FAIL disabled_strobes got=%0d want=0", strobes); end
    if (load_count !== 8'd0) begin bad++; $display("FAIL disabled_count got=%0d want=0", load_count); end
    for (int i = 0; i < 16; i++) begin
      step(i < 8, 1'b1, 8'h3C);
      if (wr_strobe === 1'b1) strobes++;
    end
    total += 4;
    if (strobes != 1) begin bad++; $display("FAIL enabled_strobes got=%0d want=1", strobes); end
    if (wr_addr !== 2'd0) begin bad++; $display("FAIL enabled_addr got=%0d want=0", wr_addr); end
    if (wr_data !== 8'h3C) begin bad++; $display("FAIL enabled_data got=%0h want=3c", wr_data); end
    if (load_count !== 8'd1) begin bad++; $display("FAIL enabled_count got=%0d want=1", load_count); end
  endtask

  task automatic test_reset_mid();
    int strobes = 0;
    int when = -1;
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 8'h77);
    btn_raw = 1'b1;
    do_reset();
    total += 4;
    if (load_count !== 8'd0) begin bad++; $display("FAIL midreset_count got=%0d want=0", load_count); end
    if (wr_data !== 8'h00) begin bad++; $display("FAIL midreset_data got=%0h want=0", wr_data); end
    if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%0h want=0", busy); end
    if (wr_strobe !== 1'b0) begin bad++; $display("FAIL midreset_strobe got=%0h want=0", wr_strobe); end
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, 8'h77);
      if (wr_strobe === 1'b1) begin strobes++; when = i; end
    end
    total += 4;
    if (strobes != 1) begin bad++; $display("FAIL midreset_strobes got=%0d want=1", strobes); end
    if (when != 6) begin bad++; $display("FAIL midreset_latency got=%0d want=6", when); end
    if (wr_addr !== 2'd0) begin bad++; $display("FAIL midreset_addr got=%0d want=0", wr_addr); end
    if (load_count !== 8'd1) begin bad++; $display("FAIL midreset_newcount got=%0d want=1", load_count); end
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_random();
    bit level = 0;
    int run_left = 0;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (run_left == 0) begin
        level = 1'($urandom_range(0, 1));
        run_left = $urandom_range(1, 9);
      end
      run_left--;
      step(level, 1'($urandom_range(0, 3) != 0), 8'($urandom));
      total += 2;
      if (wr_strobe !== m_strobe) begin bad++; $display("FAIL rand_strobe cyc=%0d got=%0h want=%0h", i, wr_strobe, m_strobe); end
      if (busy !== m_busy) begin bad++; $display("FAIL rand_busy cyc=%0d got=%0h want=%0h", i, busy, m_busy); end
      if (m_strobe) begin
        total += 3;
        if (wr_addr !== m_addr) begin bad++; $display("FAIL rand_addr cyc=%0d got=%0d want=%0d", i, wr_addr, m_addr); end
        if (wr_data !== m_data) begin bad++; $display("FAIL rand_data cyc=%0d got=%0h want=%0h", i, wr_data, m_data); end
        if (load_count !== m_count) begin bad++; $display("FAIL rand_count cyc=%0d got=%0d want=%0d", i, load_count, m_count); end
      end
    end
    total += 3;
    if (load_count !== m_count) begin bad++; $display("FAIL rand_final_count got=%0d want=%0d", load_count, m_count); end
    if (wr_data !== m_data) begin bad++; $display("FAIL rand_final_data got=%0h want=%0h", wr_data, m_data); end
    if (wr_addr !== m_addr) begin bad++; $display("FAIL rand_final_addr got=%0d want=%0d", wr_addr, m_addr); end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_clean_press();
    test_glitch();
    test_bounce();
    test_wrap();
    test_disabled();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
